mul_div_unit: RTL and testbench

//   Iterative multiply/divide unit downstream of the register file read ports.

---
 rtl/mul_div_unit_if.sv | 25 ++
 rtl/mul_div_unit.sv | 188 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between the register-file read side, the mul/div unit and writeback.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] busA;
    logic [WIDTH-1:0] busB;
    logic             WHI;
    logic             WLO;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output Start, Op, busA, busB, WHI, WLO,
        input  Busy, Done, HI, LO
    );

    modport slave (
        input  Start, Op, busA, busB, WHI, WLO,
        output Busy, Done, HI, LO
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-step shift-add multiplier / restoring divider writing architectural HI/LO.
// Define SIGNED_MD_EN to honour Op[1] as signed MULT/DIV; otherwise all ops are unsigned.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic          CLK,
    input  logic          RST_N,
    mul_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(ITERS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;   // partial product high / partial remainder
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;   // multiplier being consumed / quotient being built
    logic [WIDTH-1:0] opnd_q, opnd_d;       // multiplicand or divisor
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             busy, done, last_iter;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH+1:0] div_diff;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [WIDTH-1:0] res_hi, res_lo;

    // ---------------- FSM ----------------
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: default assignment first keeps this combinational block latch-free.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.Start) state_d = S_RUN;
            S_RUN:   if (last_iter) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    assign last_iter = (state_q == S_RUN) && (cnt_q == LAST_CNT);

    // ---------------- operand conditioning ----------------
`ifdef SIGNED_MD_EN
    logic neg_lo_q, neg_lo_d;   // quotient / product sign
    logic neg_hi_q, neg_hi_d;   // remainder sign (dividend sign)
    logic dbz_q, dbz_d;
    logic a_neg, b_neg;

    always_comb begin
        a_neg = bus.Op[1] & bus.busA[WIDTH-1];
        b_neg = bus.Op[1] & bus.busB[WIDTH-1];
        a_mag = a_neg ? (~bus.busA + 1'b1) : bus.busA;
        b_mag = b_neg ? (~bus.busB + 1'b1) : bus.busB;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dbz_d    = dbz_q;
        if (state_q == S_IDLE && bus.Start) begin
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg;
            dbz_d    = (bus.busB == '0);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dbz_q    <= dbz_d;
        end
    end
`else
    logic unused_op_sign;
    assign unused_op_sign = bus.Op[1];
    always_comb begin
        a_mag = bus.busA;
        b_mag = bus.busB;
    end
`endif

    // ---------------- one iteration ----------------
    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff = {1'b0, div_sh} - {2'b00, opnd_q};
        if (is_div_q) begin
            if (!div_diff[WIDTH+1]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_sh[WIDTH-1:0];
                step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    // Unsigned divide-by-zero falls out of the restoring loop as LO=all-ones, HI=A.
    always_comb begin
        res_hi = step_hi;
        res_lo = step_lo;
`ifdef SIGNED_MD_EN
        if (is_div_q) begin
            if (dbz_q)         res_lo = '1;
            else if (neg_lo_q) res_lo = ~step_lo + 1'b1;
            if (neg_hi_q)      res_hi = ~step_hi + 1'b1;
        end else if (neg_lo_q) begin
            {res_hi, res_lo} = ~{step_hi, step_lo} + 1'b1;
        end
`endif
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (state_q == S_IDLE) begin
            if (bus.WHI) hi_d = bus.busA;
            if (bus.WLO) lo_d = bus.busA;
            if (bus.Start) begin
                cnt_d    = '0;
                is_div_d = bus.Op[0];
                acc_hi_d = '0;
                acc_lo_d = bus.Op[0] ? a_mag : b_mag;
                opnd_d   = bus.Op[0] ? b_mag : a_mag;
            end
        end else if (state_q == S_RUN) begin
            cnt_d    = cnt_q + 1'b1;
            acc_hi_d = step_hi;
            acc_lo_d = step_lo;
            if (last_iter) begin
                hi_d = res_hi;
                lo_d = res_lo;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.Busy = busy;
    assign bus.Done = done;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, random ops against an
// arithmetic reference model, and hand-written sequences for MTHI/MTLO, re-Start and reset.
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    always #5 clk = ~clk;

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32), .ITERS(32)) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference result {HI,LO} computed straight from the arithmetic definition.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic   sgn;
        longint pa, pb, pp;
        int     sa, sb, q, r;
        sgn = 1'b0;
`ifdef SIGNED_MD_EN
        sgn = op[1];
`endif
        if (!op[0]) begin
            if (sgn) begin
                sa = a; sb = b;
                pa = sa; pb = sb;
                pp = pa * pb;
                return pp;
            end
            return {32'h0, a} * {32'h0, b};
        end
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            sa = a; sb = b;
            q = sa / sb;
            r = sa % sb;
            return {r, q};
        end
        return {a % b, a / b};
    endfunction

    // Launch one op at the next edge, then check Busy/HI/LO hold for 32 cycles, the Done pulse,
    // the result and the return to idle. Operands are scrambled after launch.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string name, input logic wlo);
        logic run_ok;
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = op; bus.busA = a; bus.busB = b; bus.WLO = wlo;
        @(posedge clk);
        if (wlo) model_lo = a;
        @(negedge clk);
        bus.Start = 1'b0; bus.WLO = 1'b0;
        bus.busA = $urandom; bus.busB = $urandom; bus.Op = 2'($urandom);
        run_ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge clk);
            if (bus.Busy !== 1'b1 || bus.Done !== 1'b0 || bus.HI !== model_hi || bus.LO !== model_lo)
                run_ok = 1'b0;
        end
        check({name, " busy/hold"}, {63'h0, run_ok}, 64'h1);
        @(negedge clk);
        check({name, " done pulse"}, {62'h0, bus.Busy, bus.Done}, 64'h1);
        check({name, " result"}, {bus.HI, bus.LO}, exp);
        model_hi = exp[63:32];
        model_lo = exp[31:0];
        @(negedge clk);
        check({name, " idle"}, {62'h0, bus.Busy, bus.Done}, 64'h0);
    endtask

    vec_t vecs[$];

    initial begin
        bus.Start = 1'b0; bus.Op = 2'b00; bus.busA = '0; bus.busB = '0;
        bus.WHI = 1'b0; bus.WLO = 1'b0;

        vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE, "multu max*2"});
        vecs.push_back('{2'b01, 32'd100, 32'd7, 32'd2, 32'd14, "divu 100/7"});
        vecs.push_back('{2'b01, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, "divu 5/0"});
        vecs.push_back('{2'b00, 32'h0, 32'h1234_5678, 32'h0, 32'h0, "multu 0*x"});
        vecs.push_back('{2'b01, 32'd3, 32'd9, 32'd3, 32'd0, "divu 3/9"});
`ifdef SIGNED_MD_EN
        vecs.push_back('{2'b10, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult -3*5"});
        vecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2"});
        vecs.push_back('{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div ovf"});
        vecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div -7/0"});
`else
        vecs.push_back('{2'b10, 32'hFFFF_FFFD, 32'd5, 32'h4, 32'hFFFF_FFF1, "mult as multu"});
        vecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'd2, 32'h1, 32'h7FFF_FFFC, "div as divu"});
        vecs.push_back('{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, "div ovf as divu"});
`endif

        // Reset, idle 5 cycles
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("reset state", {bus.HI, bus.LO}, 64'h0);
        check("reset flags", {62'h0, bus.Busy, bus.Done}, 64'h0);

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, vecs[i].name, 1'b0);

        // Random ops against the model
        for (int n = 0; n < 40; n++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom);
            a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            run_op(op, a, b, model(op, a, b), "random", 1'b0);
        end

        // Start held high through DONE: ignored there, accepted once back in IDLE
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = 2'b00; bus.busA = 32'd6; bus.busB = 32'd7;
        repeat (33) @(negedge clk);
        check("start held: done", {62'h0, bus.Busy, bus.Done}, 64'h1);
        check("start held: result", {bus.HI, bus.LO}, 64'd42);
        @(negedge clk);
        check("start in DONE ignored", {62'h0, bus.Busy, bus.Done}, 64'h0);
        @(negedge clk);
        check("start in IDLE accepted", {62'h0, bus.Busy, bus.Done}, 64'h2);
        bus.Start = 1'b0;
        repeat (33) @(negedge clk);
        check("restart result", {bus.HI, bus.LO}, 64'd42);
        model_hi = 32'h0; model_lo = 32'd42;

        // Re-Start and WHI while running are ignored; async reset mid-op clears everything
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = 2'b00; bus.busA = 32'hDEAD_BEEF; bus.busB = 32'h1111;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (4) @(negedge clk);
        bus.Start = 1'b1; bus.WHI = 1'b1; bus.busA = 32'h1234; bus.Op = 2'b01;
        repeat (6) @(negedge clk);
        bus.Start = 1'b0; bus.WHI = 1'b0;
        check("restart/whi ignored busy", {63'h0, bus.Busy}, 64'h1);
        check("whi ignored in run", {bus.HI, bus.LO}, {model_hi, model_lo});
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset hi/lo", {bus.HI, bus.LO}, 64'h0);
        check("async reset flags", {62'h0, bus.Busy, bus.Done}, 64'h0);
        model_hi = '0; model_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("no resume after reset", {62'h0, bus.Busy, bus.Done}, 64'h0);
        run_op(2'b01, 32'd1000, 32'd33, model(2'b01, 32'd1000, 32'd33), "post-reset divu", 1'b0);

        // MTHI+MTLO together in IDLE, then MTLO on the same edge as Start
        @(negedge clk);
        bus.WHI = 1'b1; bus.WLO = 1'b1; bus.busA = 32'hA5A5_A5A5;
        @(negedge clk);
        bus.WHI = 1'b0; bus.WLO = 1'b0;
        check("mthi+mtlo", {bus.HI, bus.LO}, {32'hA5A5_A5A5, 32'hA5A5_A5A5});
        model_hi = 32'hA5A5_A5A5; model_lo = 32'hA5A5_A5A5;
        run_op(2'b00, 32'd3, 32'd4, {32'h0, 32'd12}, "mtlo+start multu", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
